operand_sequencer: RTL and testbench
====================================

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: number of consecutive cycles a new synchronized button level must hold before it is accepted (legal range 2..65535).
REQ-002 SHALL have port CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sw_data  input  4  operand value from switches.
REQ-005 SHALL have port sw_cin  input  1  carry-in value from switch.
REQ-006 SHALL have port load  input  1  raw, asynchronous, bouncing pushbutton level; high = pressed.
REQ-007 SHALL have port sum  input  5  {cout, s[3:0]} returned combinationally by the downstream 4-bit ripple adder.
REQ-008 SHALL have port a  output  4  registered operand A to the adder.
REQ-009 SHALL have port b  output  4  registered operand B to the adder.
REQ-010 SHALL have port cin  output  1  registered carry-in to the adder.
REQ-011 SHALL have port result  output  5  registered copy of sum.
REQ-012 SHALL have port result_valid  output  1  high while result holds the sum of the current a, b and cin.
REQ-013 SHALL have port state  output  2  current FSM state, for LEDG display.
REQ-014 SHALL have port overflow  output  1  signed 4-bit overflow flag (see Configuration).

Function
REQ-015 SHALL pass load through a 2-flop synchronizer before any use.
REQ-016 SHALL accept a new debounced level only when the synchronized level has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any intervening match SHALL clear the counter.
REQ-017 SHALL generate a one-cycle press pulse on each debounced 0->1 transition and none on 1->0.
REQ-018 SHALL have FSM states S_LOAD_A=0, S_LOAD_B=1, S_CALC=2, S_DONE=3.
REQ-019 In S_LOAD_A, on press: a<=sw_data, then go to S_LOAD_B.
REQ-020 In S_LOAD_B, on press: b<=sw_data and cin<=sw_cin, then go to S_CALC.
REQ-021 S_CALC SHALL last exactly one cycle and ignore press; it SHALL set result<=sum and result_valid<=1, then go to S_DONE.
REQ-022 In S_DONE, on press: a<=sw_data, result_valid<=0, then go to S_LOAD_B; result SHALL hold its old value until the next S_CALC.
REQ-023 Absent a press, a, b, cin, result and result_valid SHALL hold.
REQ-024 Switch changes without a press SHALL have no effect on any output.
REQ-025 Latency SHALL be exactly one cycle from the cycle of the B press to result_valid=1.

Reset
REQ-026 reset SHALL override every other input in the same cycle, including a coincident press.
REQ-027 On reset: a=0, b=0, cin=0, result=0, result_valid=0, overflow=0, state=S_LOAD_A, debounce counter=0, debounced level=0, synchronizer flops=0.
REQ-028 reset asserted mid-sequence (any state) SHALL discard partial operands; a button still held at reset release SHALL NOT produce a press until it is released and pressed again.

Configuration
REQ-029 With OPERAND_OVERFLOW_EN defined, S_CALC SHALL set overflow<=(a[3]==b[3])&&(sum[3]!=a[3]), with the same timing and clearing as result_valid.
REQ-030 Without OPERAND_OVERFLOW_EN, overflow SHALL be tied to 0 and no overflow logic SHALL exist.

Structure
REQ-031 State encodings and the operand width constant (4) SHALL live in shared package operand_seq_pkg.
REQ-032 Synchronizer, debounce counter and edge detect SHALL form sub-module load_debounce (ports: clock, reset, raw, press).
REQ-033 The adder SHALL remain external; this block SHALL contain no addition logic.

Verification
REQ-034 Clean press sequence, DEBOUNCE_CYCLES=4: sw_data=5 then press; sw_data=9, sw_cin=1 then press -> a=5, b=9, cin=1; result=15 and result_valid=1 one cycle after S_CALC.
REQ-035 Bouncing input: load toggles every 2 cycles for 20 cycles, then held high -> exactly one press, after 2+4 stable cycles.
REQ-036 Press in S_DONE with sw_data=3 -> a=3, result_valid=0, state=S_LOAD_B, result unchanged.
REQ-037 reset asserted in S_LOAD_B coincident with a press -> all outputs 0, state=S_LOAD_A, no operand captured.
REQ-038 OPERAND_OVERFLOW_EN defined: a=7, b=1, cin=0 -> overflow=1; a=8, b=8 -> overflow=1; a=3, b=2 -> overflow=0. Undefined: overflow=0 throughout.

Source files
------------

// File: rtl/operand_seq_pkg.sv
// Shared definitions for the operand sequencer: operand width, FSM encodings
// and the signed-overflow helper used when OPERAND_OVERFLOW_EN is defined.
package operand_seq_pkg;

  localparam int unsigned OPERAND_W = 4;
  localparam int unsigned SUM_W     = OPERAND_W + 1;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_CALC   = 2'd2,
    S_DONE   = 2'd3
  } seq_state_e;

  // Two operands of equal sign whose result sign differs.
  function automatic logic signed_ovf(
    input logic [OPERAND_W-1:0] op_a,
    input logic [OPERAND_W-1:0] op_b,
    input logic [SUM_W-1:0]     sum_v
  );
    return (op_a[OPERAND_W-1] == op_b[OPERAND_W-1]) &&
           (sum_v[OPERAND_W-1] != op_a[OPERAND_W-1]);
  endfunction

endpackage

// File: rtl/operand_sequencer_load_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, debounce counter and rising-edge press pulse.
// A button held through reset is locked out until it has read released for a full window.
module load_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam logic [15:0] CNT_LAST    = 16'(DEBOUNCE_CYCLES - 1);
  // Two extra cycles cover the synchronizer refilling after reset.
  localparam logic [16:0] SETTLE_LAST = 17'(DEBOUNCE_CYCLES + 1);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic        blocked_q, blocked_d;
  logic [16:0] settle_q, settle_d;
  logic        press_q, press_d;

  // Debounce counter, level acceptance and post-reset lockout next-state logic.
  always_comb begin
    level_d   = level_q;
    cnt_d     = 16'd0;
    blocked_d = blocked_q;
    settle_d  = 17'd0;
    press_d   = 1'b0;

    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q & ~blocked_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = 16'd0;
    end

    if (blocked_q) begin
      if (sync2_q) begin
        settle_d = 17'd0;
      end else if (settle_q == SETTLE_LAST) begin
        blocked_d = 1'b0;
        settle_d  = 17'd0;
      end else begin
        settle_d = settle_q + 17'd1;
      end
    end else begin
      settle_d = 17'd0;
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= 16'd0;
      blocked_q <= 1'b1;
      settle_q  <= 17'd0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
      settle_q  <= settle_d;
      press_q   <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/operand_sequencer.sv
// Steps a debounced pushbutton through loading A, loading B/cin and capturing the external
// adder's sum. Define OPERAND_OVERFLOW_EN to register a signed-overflow flag alongside result.
module operand_sequencer
  import operand_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [OPERAND_W-1:0] sw_data,
  input  logic                 sw_cin,
  input  logic                 load,
  input  logic [SUM_W-1:0]     sum,
  output logic [OPERAND_W-1:0] a,
  output logic [OPERAND_W-1:0] b,
  output logic                 cin,
  output logic [SUM_W-1:0]     result,
  output logic                 result_valid,
  output logic [1:0]           state,
  output logic                 overflow
);

  logic                 press_s;
  seq_state_e           state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
  logic                 cin_q, cin_d;
  logic [SUM_W-1:0]     result_q, result_d;
  logic                 valid_q, valid_d;

  load_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock(CLOCK_50),
    .reset(reset),
    .raw  (load),
    .press(press_s)
  );

  // Sequencer next-state and operand/result capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    result_d = result_q;
    valid_d  = valid_q;

    case (state_q)
      S_LOAD_A: begin
        if (press_s) begin
          a_d     = sw_data;
          state_d = S_LOAD_B;
        end else begin
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_B: begin
        if (press_s) begin
          b_d     = sw_data;
          cin_d   = sw_cin;
          state_d = S_CALC;
        end else begin
          state_d = S_LOAD_B;
        end
      end
      S_CALC: begin
        result_d = sum;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (press_s) begin
          a_d     = sw_data;
          valid_d = 1'b0;
          state_d = S_LOAD_B;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_LOAD_A;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_LOAD_A;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      cin_q    <= 1'b0;
      result_q <= 5'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

`ifdef OPERAND_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Overflow follows result_valid: set in S_CALC, cleared by the next A press.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_CALC) begin
      ovf_d = signed_ovf(a_q, b_q, sum);
    end else if ((state_q == S_DONE) && press_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign a            = a_q;
  assign b            = b_q;
  assign cin          = cin_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with DEBOUNCE_CYCLES=4 and a behavioural
// 4-bit adder on the sum input; overflow expectations follow OPERAND_OVERFLOW_EN.
module tb_operand_sequencer;

`ifdef OPERAND_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [3:0] sw_data;
  logic       sw_cin;
  logic       load;
  logic [4:0] sum;
  logic [3:0] a, b;
  logic       cin;
  logic [4:0] result;
  logic       result_valid;
  logic [1:0] state;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cyc0 = 0;
  int n_chg = 0;
  int st_chg_cyc = -1;
  int vld_rise_cyc = -1;
  logic [1:0] st_prev;
  logic       vld_prev;

  operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .sw_data     (sw_data),
    .sw_cin      (sw_cin),
    .load        (load),
    .sum         (sum),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .result      (result),
    .result_valid(result_valid),
    .state       (state),
    .overflow    (overflow)
  );

  // Downstream ripple adder stand-in.
  assign sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};

  always #5 CLOCK_50 = ~CLOCK_50;

  // Track cycle count plus first state change and result_valid rise after a mark.
  always @(posedge CLOCK_50) begin
    cyc = cyc + 1;
    #1;
    if (state !== st_prev) begin
      n_chg = n_chg + 1;
      if (st_chg_cyc < 0) st_chg_cyc = cyc;
    end
    if (result_valid === 1'b1 && vld_prev !== 1'b1 && vld_rise_cyc < 0) vld_rise_cyc = cyc;
    st_prev  = state;
    vld_prev = result_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clean press: 10 cycles held, then released and allowed to settle.
  task automatic press_btn(input logic [3:0] d, input logic c);
    @(negedge CLOCK_50);
    sw_data      = d;
    sw_cin       = c;
    load         = 1'b1;
    st_chg_cyc   = -1;
    vld_rise_cyc = -1;
    n_chg        = 0;
    cyc0         = cyc;
    repeat (10) @(negedge CLOCK_50);
    load = 1'b0;
    repeat (12) @(negedge CLOCK_50);
  endtask

  task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic ec, input logic [4:0] er, input logic ev,
                           input logic [1:0] es, input logic eo);
    check_eq({tag, ".a"}, 32'(a), 32'(ea));
    check_eq({tag, ".b"}, 32'(b), 32'(eb));
    check_eq({tag, ".cin"}, 32'(cin), 32'(ec));
    check_eq({tag, ".result"}, 32'(result), 32'(er));
    check_eq({tag, ".valid"}, 32'(result_valid), 32'(ev));
    check_eq({tag, ".state"}, 32'(state), 32'(es));
    check_eq({tag, ".ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    sw_data = 4'd0;
    sw_cin  = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    check_all("reset", 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    repeat (10) @(negedge CLOCK_50);

    // A press: state change 7 edges after the button goes high.
    press_btn(4'd5, 1'b0);
    check_eq("a_press.edge", 32'(st_chg_cyc), 32'(cyc0 + 7));
    check_all("a_press", 4'd5, 4'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);

    // Switches move without a press.
    sw_data = 4'd9;
    sw_cin  = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check_all("sw_only", 4'd5, 4'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);

    // B press: S_CALC one cycle, then valid.
    press_btn(4'd9, 1'b1);
    check_eq("b_press.calc_edge", 32'(st_chg_cyc), 32'(cyc0 + 7));
    check_eq("b_press.valid_edge", 32'(vld_rise_cyc), 32'(cyc0 + 8));
    check_eq("b_press.nchg", 32'(n_chg), 32'd2);
    check_all("calc_5_9_1", 4'd5, 4'd9, 1'b1, 5'd15, 1'b1, 2'd3, 1'b0);

    // Bouncing press in S_DONE with sw_data=3.
    @(negedge CLOCK_50);
    sw_data    = 4'd3;
    sw_cin     = 1'b0;
    n_chg      = 0;
    st_chg_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      load = (((i / 2) % 2) == 0);
      @(negedge CLOCK_50);
    end
    check_eq("bounce.no_press", 32'(n_chg), 32'd0);
    load = 1'b1;
    cyc0 = cyc;
    repeat (12) @(negedge CLOCK_50);
    load = 1'b0;
    repeat (12) @(negedge CLOCK_50);
    check_eq("bounce.edge", 32'(st_chg_cyc), 32'(cyc0 + 7));
    check_eq("bounce.nchg", 32'(n_chg), 32'd1);
    check_all("done_press", 4'd3, 4'd9, 1'b1, 5'd15, 1'b0, 2'd1, 1'b0);

    press_btn(4'd2, 1'b0);
    check_all("calc_3_2", 4'd3, 4'd2, 1'b0, 5'd5, 1'b1, 2'd3, 1'b0);

    press_btn(4'd7, 1'b0);
    press_btn(4'd1, 1'b0);
    check_all("calc_7_1", 4'd7, 4'd1, 1'b0, 5'd8, 1'b1, 2'd3, OVF_EN);

    press_btn(4'd8, 1'b0);
    check_eq("ovf_clear_on_a", 32'(overflow), 32'd0);
    press_btn(4'd8, 1'b0);
    check_all("calc_8_8", 4'd8, 4'd8, 1'b0, 5'h10, 1'b1, 2'd3, OVF_EN);

    // Reset in S_LOAD_B coincident with the press pulse.
    press_btn(4'd4, 1'b0);
    check_all("pre_reset", 4'd4, 4'd8, 1'b0, 5'h10, 1'b0, 2'd1, 1'b0);
    @(negedge CLOCK_50);
    sw_data = 4'hE;
    sw_cin  = 1'b1;
    load    = 1'b1;
    repeat (6) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check_all("reset_press", 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    repeat (20) @(negedge CLOCK_50);
    check_all("held_after_reset", 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    load = 1'b0;
    repeat (16) @(negedge CLOCK_50);
    press_btn(4'd6, 1'b0);
    check_all("repress", 4'd6, 4'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
